// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable UART receiver with a ready/valid output.
//
// Optional feature: define UART_RX_PARITY_EN to add the i_parity port and
// the PARITY state. Without it, o_parity_err is tied low.
//
// Parameters
//   DATA_BITS  data bits per frame (5..9)
//   STOP_BITS  stop bits checked per frame (1 or 2)
// Ports
//   i_clk        system clock (23.04 MHz)
//   i_rst        asynchronous active-low reset
//   i_baud       baud select, latched at the start edge:
//                0..5 = 100/200/400/600/1200/2400 clocks per bit,
//                6/7  = 4800 clocks per bit
//   i_parity     (UART_RX_PARITY_EN only) 0/3 none, 1 even, 2 odd;
//                latched at the start edge
//   i_rx         serial line, idle high
//   i_ready      consumer accepts o_data while o_valid is high
//   o_data       received character, first line bit in the LSB
//   o_valid      o_data holds an unconsumed character
//   o_frame_err  a stop bit was sampled low for the held character
//   o_parity_err parity mismatch for the held character
//   o_overrun    sticky: a frame was dropped while o_valid was high
//   o_busy       receive FSM is not idle
module uart_rx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [2:0]           i_baud,
`ifdef UART_RX_PARITY_EN
  input  logic [1:0]           i_parity,
`endif
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [12:0]           cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [2:0]            baud_q, baud_d;
  logic                  smp0_q, smp0_d;
  logic                  smp1_q, smp1_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  fe_q, fe_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_q, perr_d;
  logic                  ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic [1:0]            par_q, par_d;
  logic                  pe_q, pe_d;
`endif

  // Synchronizer plus one extra stage for falling-edge detection.
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  logic [12:0] period, half;
  logic        fall, at_s0, at_s1, at_vote, vote, fe_now, done;

  always_comb begin
    case (baud_q)
      3'd0:    period = 13'd100;
      3'd1:    period = 13'd200;
      3'd2:    period = 13'd400;
      3'd3:    period = 13'd600;
      3'd4:    period = 13'd1200;
      3'd5:    period = 13'd2400;
      default: period = 13'd4800;
    endcase
  end

  assign half    = period >> 1;
  assign fall    = rx_prev_q & ~rx_s2_q;
  assign at_s0   = (cnt_q == half - 13'd1);
  assign at_s1   = (cnt_q == half);
  assign at_vote = (cnt_q == half + 13'd1);
  // 2-of-3 over the two stored samples and the current one.
  assign vote    = (smp0_q & smp1_q) | (smp0_q & rx_s2_q) | (smp1_q & rx_s2_q);

  // One modulo-period counter spans the whole frame: the edge cycle is
  // count 0, so every bit is voted at count half+1 of its own period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    smp0_d  = smp0_q;
    smp1_d  = smp1_q;
    shift_d = shift_q;
    fe_d    = fe_q;
    fe_now  = fe_q;
    done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = pe_q;
`endif

    if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == period - 13'd1) ? 13'd0 : cnt_q + 13'd1;
      if (at_s0) smp0_d = rx_s2_q;
      if (at_s1) smp1_d = rx_s2_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          cnt_d   = 13'd1;
          bit_d   = 4'd0;
          baud_d  = i_baud;
          fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_d   = i_parity;
          pe_d    = 1'b0;
`endif
        end
      end
      S_START: begin
        if (at_vote) begin
          if (vote) begin
            state_d = S_IDLE;     // false start: silently drop
            cnt_d   = 13'd0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (at_vote) begin
          shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = 4'd0;
`ifdef UART_RX_PARITY_EN
            state_d = (par_q == 2'd1 || par_q == 2'd2) ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_vote) begin
          // par_q[1] is set only for odd parity.
          pe_d    = ^shift_q ^ vote ^ par_q[1];
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (at_vote) begin
          fe_now = fe_q | ~vote;
          fe_d   = fe_now;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            state_d = S_IDLE;     // no wait for line high after an error
            cnt_d   = 13'd0;
            bit_d   = 4'd0;
            done    = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output holding register. A completing frame may reload it in the same
  // cycle the previous character is consumed.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    if (valid_q && i_ready) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (done) begin
      if (!valid_q || i_ready) begin
        data_d  = shift_q;
        ferr_d  = fe_now;
`ifdef UART_RX_PARITY_EN
        perr_d  = pe_q;
`else
        perr_d  = 1'b0;
`endif
        valid_d = 1'b1;
      end else begin
        ovr_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      baud_q    <= '0;
      smp0_q    <= 1'b1;
      smp1_q    <= 1'b1;
      shift_q   <= '0;
      fe_q      <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= '0;
      pe_q      <= 1'b0;
`endif
    end else begin
      rx_s1_q   <= i_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      baud_q    <= baud_d;
      smp0_q    <= smp0_d;
      smp1_q    <= smp1_d;
      shift_q   <= shift_d;
      fe_q      <= fe_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule
